// File: rtl/write_engine_pkg.sv
// Shared types for the memcpy write engine: CAPI command/response line
// layouts, buffer status, the write-engine FSM state enum and the helper
// that converts an element count into a CAPI partial-write size.
package write_engine_pkg;

    localparam int unsigned ARRAY_SIZE_BITS     = 32;
    localparam int unsigned CACHELINE_SIZE_BITS = 1024;
    localparam logic [ARRAY_SIZE_BITS-1:0] CACHELINE_ARRAY_NUM = 32;
    localparam logic [7:0]  DATA_WRITE_CONTROL_ID = 8'h04;

    typedef enum logic [12:0] {
        CMD_NOP    = 13'h0000,
        WRITE_NA   = 13'h0D00,
        WRITE_MS   = 13'h0D60,
        READ_CL_NA = 13'h0A00
    } command_type;

    typedef enum logic [2:0] {
        STRICT = 3'b000,
        ABORT  = 3'b001,
        PAGE   = 3'b010,
        PREF   = 3'b011,
        SPEC   = 3'b111
    } trans_order_behavior_t;

    typedef enum logic [1:0] {
        CMD_INVALID,
        CMD_READ,
        CMD_WRITE,
        CMD_WED
    } command_class;

    typedef enum logic [1:0] {
        STRUCT_INVALID,
        READ_DATA,
        WRITE_DATA
    } array_struct_type;

    typedef enum logic [2:0] {
        WRITE_STREAM_RESET,
        WRITE_STREAM_IDLE,
        WRITE_STREAM_SET,
        WRITE_STREAM_START,
        WRITE_STREAM,
        WRITE_STREAM_FINAL
    } write_state;

    typedef struct packed {
        logic [7:0]                 cu_id_x;
        logic [7:0]                 cu_id_y;
        command_class               cmd_type;
        array_struct_type           array_struct;
        logic [ARRAY_SIZE_BITS-1:0] real_size;
        logic [ARRAY_SIZE_BITS-1:0] real_size_bytes;
        logic [63:0]                address_offset;
    } CommandTagLine;

    typedef struct packed {
        logic [63:0]                wed_address;
        logic [63:0]                array_send;
        logic [63:0]                array_receive;
        logic [ARRAY_SIZE_BITS-1:0] size_send;
    } WED_ControlInterface;

    typedef struct packed {
        logic                valid;
        WED_ControlInterface payload;
    } WEDInterface;

    typedef struct packed {
        logic                           valid;
        CommandTagLine                  cmd;
        logic [CACHELINE_SIZE_BITS-1:0] data;
    } ReadWriteDataLine;

    typedef struct packed {
        CommandTagLine cmd;
        logic [7:0]    response;
    } ResponseInterface;

    typedef struct packed {
        logic             valid;
        ResponseInterface payload;
    } ResponseBufferLine;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
    } BufferStatus;

    typedef struct packed {
        logic                  valid;
        command_type           command;
        logic [63:0]           address;
        logic [11:0]           size;
        CommandTagLine         cmd;
        trans_order_behavior_t abt;
    } CommandBufferLine;

    // Byte count of real_size 4-byte elements, rounded up to a power of two
    // (1..128) as required for a partial-line CAPI write.
    function automatic logic [11:0] cmd_size_calculate(input logic [ARRAY_SIZE_BITS-1:0] real_size);
        logic [ARRAY_SIZE_BITS+1:0] bytes;
        logic [11:0]                size;
        bytes = {real_size, 2'b00};
        size  = 12'h001;
        for (int unsigned i = 0; i < 7; i++) begin
            if ({{(ARRAY_SIZE_BITS-10){1'b0}}, size} < bytes) begin
                size = size << 1;
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/write_engine_fifo.sv
// Synchronous show-ahead FIFO of ReadWriteDataLine entries.
// Ports: clock/rstn (async active-low), push_i/din_i write side,
// pop_i read side with dout_o presenting the head entry, and
// full_o/empty_o/alfull_o status. Pushes into a full FIFO are dropped.
module write_engine_fifo
    import write_engine_pkg::*;
#(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned ALFULL_MARGIN = 4
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             push_i,
    input  ReadWriteDataLine din_i,
    input  logic             pop_i,
    output ReadWriteDataLine dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             alfull_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ReadWriteDataLine mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign alfull_o = (count_q >= (AW+1)'(DEPTH - ALFULL_MARGIN));
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign dout_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/write_engine.sv
// Memcpy write engine: turns returned read-data cachelines into CAPI write
// commands (WRITE_NA for full lines, WRITE_MS for partial lines) aimed at
// wed.array_receive + address_offset, and counts confirmed elements.
// Ports: clock/rstn (async active-low), write_enabled_in, wed_request_in,
// read_data_in, write_response_in, write_command/data_buffer_status in;
// write_command_out, write_data_out, write_job_counter_done out.
// Optional macro WRITE_ENGINE_FIFO_EN inserts a WRITE_FIFO_DEPTH line FIFO
// that stalls on downstream alfull (adds one cycle of latency).
module write_engine
    import write_engine_pkg::*;
#(
    parameter logic [7:0]  CU_WRITE_CONTROL_ID = DATA_WRITE_CONTROL_ID,
    parameter int unsigned WRITE_FIFO_DEPTH    = 32
) (
    input  logic                       clock,
    input  logic                       rstn,
    input  logic                       write_enabled_in,
    input  WEDInterface                wed_request_in,
    input  ReadWriteDataLine           read_data_in,
    input  ResponseBufferLine          write_response_in,
    input  BufferStatus                write_command_buffer_status,
    input  BufferStatus                write_data_buffer_status,
    output CommandBufferLine           write_command_out,
    output ReadWriteDataLine           write_data_out,
    output logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done
);

    logic                       enabled_q;
    logic                       wed_valid_q, rd_valid_q, rsp_valid_q;
    WED_ControlInterface        wed_q, wed_drv_q;
    ReadWriteDataLine           rd_q;
    ResponseInterface           rsp_q;
    BufferStatus                cmd_status_q, data_status_q;
    write_state                 state_q, state_d;
    logic [63:0]                array_receive_q;
    logic [ARRAY_SIZE_BITS-1:0] size_send_q, counter_q, counter_d;
    ReadWriteDataLine           src_line;
    logic                       src_take;
    CommandTagLine              tag;
    CommandBufferLine           bld_cmd_d, bld_cmd_q, out_cmd_q;
    ReadWriteDataLine           bld_data_d, bld_data_q, out_data_q;
    logic                       bld_valid_q, out_valid_q;

    // ---------------- input registers ----------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q     <= 1'b0;
            wed_valid_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            cmd_status_q  <= '{alfull: 1'b0, full: 1'b0, empty: 1'b1};
            data_status_q <= '{alfull: 1'b0, full: 1'b0, empty: 1'b1};
        end else begin
            enabled_q     <= write_enabled_in;
            wed_valid_q   <= wed_request_in.valid;
            rd_valid_q    <= read_data_in.valid;
            rsp_valid_q   <= write_response_in.valid;
            cmd_status_q  <= write_command_buffer_status;
            data_status_q <= write_data_buffer_status;
        end
    end

    always_ff @(posedge clock) begin
        if (wed_request_in.valid) begin
            wed_q <= wed_request_in.payload;
        end
        rd_q  <= read_data_in;
        rsp_q <= write_response_in.payload;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= WRITE_STREAM_RESET;
        end else if (enabled_q) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WRITE_STREAM_RESET: state_d = WRITE_STREAM_IDLE;
            WRITE_STREAM_IDLE:  if (wed_valid_q) state_d = WRITE_STREAM_SET;
            WRITE_STREAM_SET:   state_d = WRITE_STREAM_START;
            WRITE_STREAM_START: state_d = WRITE_STREAM;
            WRITE_STREAM:       if (counter_q >= size_send_q) state_d = WRITE_STREAM_FINAL;
            WRITE_STREAM_FINAL: state_d = WRITE_STREAM_FINAL;
            default:            state_d = WRITE_STREAM_RESET;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            array_receive_q <= '0;
            size_send_q     <= '0;
        end else if (enabled_q && state_q == WRITE_STREAM_SET) begin
            array_receive_q <= wed_q.array_receive;
            size_send_q     <= wed_q.size_send;
        end
    end

    always_ff @(posedge clock) begin
        if (enabled_q && state_q == WRITE_STREAM_SET) begin
            wed_drv_q <= wed_q;
        end
    end

    // ---------------- response counter ----------------
    // Not cleared in SET, so a response coinciding with SET is kept.
    assign counter_d = counter_q + (rsp_valid_q ? rsp_q.cmd.real_size : '0);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            counter_q <= '0;
        end else if (enabled_q) begin
            counter_q <= counter_d;
        end
    end

    assign write_job_counter_done = counter_q;

    // ---------------- line source ----------------
`ifdef WRITE_ENGINE_FIFO_EN
    ReadWriteDataLine fifo_head;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_alfull;

    assign fifo_push = enabled_q && rd_valid_q && (state_q == WRITE_STREAM);
    assign fifo_pop  = enabled_q && !fifo_empty && !cmd_status_q.alfull && !data_status_q.alfull;

    write_engine_fifo #(
        .DEPTH(WRITE_FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .din_i   (rd_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .alfull_o(fifo_alfull)
    );

    assign src_line = fifo_head;
    assign src_take = fifo_pop;

    logic unused_bits;
    assign unused_bits = ^{wed_drv_q, rsp_q, cmd_status_q, data_status_q,
                           fifo_full, fifo_alfull, fifo_head.valid};
`else
    assign src_line = rd_q;
    assign src_take = rd_valid_q && (state_q == WRITE_STREAM);

    logic unused_bits;
    assign unused_bits = ^{wed_drv_q, rsp_q, rd_q.valid, cmd_status_q, data_status_q,
                           32'(WRITE_FIFO_DEPTH)};
`endif

    // ---------------- command build ----------------
    always_comb begin
        tag              = src_line.cmd;
        tag.cu_id_x      = CU_WRITE_CONTROL_ID;
        tag.cu_id_y      = CU_WRITE_CONTROL_ID;
        tag.cmd_type     = CMD_WRITE;
        tag.array_struct = WRITE_DATA;

        bld_cmd_d         = '0;
        bld_cmd_d.valid   = 1'b1;
        bld_cmd_d.cmd     = tag;
        bld_cmd_d.abt     = STRICT;
        bld_cmd_d.address = array_receive_q + src_line.cmd.address_offset;
        if (src_line.cmd.real_size == CACHELINE_ARRAY_NUM) begin
            bld_cmd_d.command = WRITE_NA;
            bld_cmd_d.size    = 12'h080;
        end else begin
            bld_cmd_d.command = WRITE_MS;
            bld_cmd_d.size    = cmd_size_calculate(src_line.cmd.real_size);
        end

        bld_data_d       = '0;
        bld_data_d.valid = 1'b1;
        bld_data_d.cmd   = tag;
        bld_data_d.data  = src_line.data;
    end

    // ---------------- build and output stages ----------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            bld_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (enabled_q) begin
            bld_valid_q <= src_take;
            out_valid_q <= bld_valid_q;
        end
    end

    always_ff @(posedge clock) begin
        if (enabled_q && src_take) begin
            bld_cmd_q  <= bld_cmd_d;
            bld_data_q <= bld_data_d;
        end
        if (enabled_q && bld_valid_q) begin
            out_cmd_q  <= bld_cmd_q;
            out_data_q <= bld_data_q;
        end
    end

    always_comb begin
        write_command_out       = out_cmd_q;
        write_command_out.valid = out_valid_q;
        write_data_out          = out_data_q;
        write_data_out.valid    = out_valid_q;
    end

endmodule

// File: tb/tb_write_engine.sv
module tb_write_engine;
    import write_engine_pkg::*;

`ifdef WRITE_ENGINE_FIFO_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                       clock;
    logic                       rstn;
    logic                       write_enabled_in;
    WEDInterface                wed_request_in;
    ReadWriteDataLine           read_data_in;
    ResponseBufferLine          write_response_in;
    BufferStatus                write_command_buffer_status;
    BufferStatus                write_data_buffer_status;
    CommandBufferLine           write_command_out;
    ReadWriteDataLine           write_data_out;
    logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done;

    write_engine #(
        .CU_WRITE_CONTROL_ID(DATA_WRITE_CONTROL_ID),
        .WRITE_FIFO_DEPTH   (32)
    ) dut (
        .clock                      (clock),
        .rstn                       (rstn),
        .write_enabled_in           (write_enabled_in),
        .wed_request_in             (wed_request_in),
        .read_data_in               (read_data_in),
        .write_response_in          (write_response_in),
        .write_command_buffer_status(write_command_buffer_status),
        .write_data_buffer_status   (write_data_buffer_status),
        .write_command_out          (write_command_out),
        .write_data_out             (write_data_out),
        .write_job_counter_done     (write_job_counter_done)
    );

    typedef struct {
        command_type command;
        logic [63:0] addr;
        logic [11:0] size;
        logic [31:0] rs;
        logic [63:0] off;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clock) begin
        exp_t           e;
        logic [1023:0]  ed;
        logic           ok;
        if (write_command_out.valid || write_data_out.valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cycle %0d: got cmd %h addr %h, required no output",
                         cyc, write_command_out.command, write_command_out.address);
            end else begin
                e  = sb.pop_front();
                ed = {32{e.off[31:0]}};
                ok = write_command_out.valid && write_data_out.valid &&
                     write_command_out.command == e.command &&
                     write_command_out.address == e.addr &&
                     write_command_out.size == e.size &&
                     write_command_out.cmd.real_size == e.rs &&
                     write_command_out.cmd.address_offset == e.off &&
                     write_command_out.cmd.cmd_type == CMD_WRITE &&
                     write_command_out.cmd.array_struct == WRITE_DATA &&
                     write_command_out.cmd.cu_id_x == DATA_WRITE_CONTROL_ID &&
                     write_command_out.cmd.cu_id_y == DATA_WRITE_CONTROL_ID &&
                     write_command_out.abt == STRICT &&
                     write_data_out.cmd.address_offset == e.off &&
                     write_data_out.data == ed &&
                     (e.cyc < 0 || e.cyc == cyc);
                if (!ok) begin
                    errors++;
                    $display("FAIL sb_cmd cycle %0d: got cmd %h addr %h size %h rs %0d off %h dv %b, required cmd %h addr %h size %h rs %0d off %h cycle %0d",
                             cyc, write_command_out.command, write_command_out.address,
                             write_command_out.size, write_command_out.cmd.real_size,
                             write_command_out.cmd.address_offset, write_data_out.valid,
                             e.command, e.addr, e.size, e.rs, e.off, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        sb.delete();
        rstn = 1'b1;
        repeat (5) tick();
    endtask

    task automatic send_wed(input logic [31:0] size, input logic [63:0] arr);
        wed_request_in.valid                 = 1'b1;
        wed_request_in.payload.size_send     = size;
        wed_request_in.payload.array_receive = arr;
        tick();
        wed_request_in.valid = 1'b0;
    endtask

    // lat_extra < 0 skips the exact-cycle check; accept=0 pushes nothing.
    task automatic send_line(input logic [31:0] rs, input logic [63:0] off,
                             input command_type ecmd, input logic [63:0] eaddr,
                             input logic [11:0] esize, input bit accept, input int lat_extra);
        exp_t e;
        read_data_in                    = '0;
        read_data_in.valid              = 1'b1;
        read_data_in.cmd.real_size      = rs;
        read_data_in.cmd.real_size_bytes = rs << 2;
        read_data_in.cmd.address_offset = off;
        read_data_in.data               = {32{off[31:0]}};
        if (accept) begin
            e.command = ecmd;
            e.addr    = eaddr;
            e.size    = esize;
            e.rs      = rs;
            e.off     = off;
            e.cyc     = (lat_extra < 0) ? -1 : cyc + LAT + lat_extra;
            sb.push_back(e);
        end
        tick();
        read_data_in.valid = 1'b0;
    endtask

    task automatic send_resp(input logic [31:0] rs);
        write_response_in                       = '0;
        write_response_in.valid                 = 1'b1;
        write_response_in.payload.cmd.real_size = rs;
        tick();
        write_response_in.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn                        = 1'b0;
        write_enabled_in            = 1'b1;
        wed_request_in              = '0;
        read_data_in                = '0;
        write_response_in           = '0;
        write_command_buffer_status = '{alfull: 1'b0, full: 1'b0, empty: 1'b1};
        write_data_buffer_status    = '{alfull: 1'b0, full: 1'b0, empty: 1'b1};
        repeat (3) tick();

        // Reset state
        check("reset_cmd_valid", 64'(write_command_out.valid), 64'd0);
        check("reset_data_valid", 64'(write_data_out.valid), 64'd0);
        check("reset_counter", 64'(write_job_counter_done), 64'd0);
        check("reset_state", 64'(dut.state_q), 64'(WRITE_STREAM_RESET));
        rstn = 1'b1;
        repeat (5) tick();
        check("idle_state", 64'(dut.state_q), 64'(WRITE_STREAM_IDLE));

        // Gating: a line in IDLE is dropped
        send_line(32, 64'h0, WRITE_NA, 64'h0, 12'h080, 1'b0, 0);
        repeat (6) tick();
        check("gating_counter", 64'(write_job_counter_done), 64'd0);

        // Basic full line
        send_wed(32, 64'h1000);
        repeat (3) tick();
        check("basic_stream_state", 64'(dut.state_q), 64'(WRITE_STREAM));
        send_line(32, 64'h0, WRITE_NA, 64'h1000, 12'h080, 1'b1, 0);
        repeat (6) tick();
        send_resp(32);
        repeat (3) tick();
        check("basic_counter", 64'(write_job_counter_done), 64'd32);
        check("basic_final", 64'(dut.state_q), 64'(WRITE_STREAM_FINAL));
        check("basic_drained", 64'(sb.size()), 64'd0);

        // Partial line: 8 elements -> 32 bytes
        do_reset();
        send_wed(40, 64'h1000);
        repeat (3) tick();
        send_line(32, 64'h0,  WRITE_NA, 64'h1000, 12'h080, 1'b1, 0);
        send_line(8,  64'h80, WRITE_MS, 64'h1080, 12'h020, 1'b1, 0);
        repeat (6) tick();
        send_resp(32);
        repeat (3) tick();
        check("partial_counter_mid", 64'(write_job_counter_done), 64'd32);
        check("partial_not_final", 64'(dut.state_q), 64'(WRITE_STREAM));
        send_resp(8);
        repeat (3) tick();
        check("partial_counter", 64'(write_job_counter_done), 64'd40);
        check("partial_final", 64'(dut.state_q), 64'(WRITE_STREAM_FINAL));
        check("partial_drained", 64'(sb.size()), 64'd0);

        // Response during SET, address wrap, enable freeze
        do_reset();
        send_wed(80, 64'hFFFF_FFFF_FFFF_FFC0);
        send_resp(16);
        repeat (2) tick();
        check("set_cycle_resp", 64'(write_job_counter_done), 64'd16);
        check("enable_stream_state", 64'(dut.state_q), 64'(WRITE_STREAM));
        send_line(32, 64'h80, WRITE_NA, 64'h40, 12'h080, 1'b1, 5);
        write_enabled_in = 1'b0;
        tick();
        tick();
        check("enable_frozen_out", 64'(write_command_out.valid), 64'd0);
        check("enable_frozen_state", 64'(dut.state_q), 64'(WRITE_STREAM));
        repeat (3) tick();
        write_enabled_in = 1'b1;
        repeat (6) tick();
        check("enable_drained", 64'(sb.size()), 64'd0);
        send_resp(32);
        send_resp(32);
        repeat (3) tick();
        check("enable_counter", 64'(write_job_counter_done), 64'd80);
        check("enable_final", 64'(dut.state_q), 64'(WRITE_STREAM_FINAL));

`ifdef WRITE_ENGINE_FIFO_EN
        // FIFO holds lines while downstream is almost full
        do_reset();
        send_wed(128, 64'h3000);
        repeat (3) tick();
        write_data_buffer_status.alfull = 1'b1;
        send_line(32, 64'h000, WRITE_NA, 64'h3000, 12'h080, 1'b1, -1);
        send_line(32, 64'h080, WRITE_NA, 64'h3080, 12'h080, 1'b1, -1);
        send_line(32, 64'h100, WRITE_NA, 64'h3100, 12'h080, 1'b1, -1);
        send_line(32, 64'h180, WRITE_NA, 64'h3180, 12'h080, 1'b1, -1);
        repeat (10) tick();
        check("fifo_held", 64'(sb.size()), 64'd4);
        write_data_buffer_status.alfull = 1'b0;
        repeat (12) tick();
        check("fifo_drained", 64'(sb.size()), 64'd0);
`endif

        // Reset mid-stream with two lines in flight
        do_reset();
        send_wed(64, 64'h1000);
        repeat (3) tick();
        send_resp(8);
        repeat (3) tick();
        check("midreset_counter_pre", 64'(write_job_counter_done), 64'd8);
        send_line(32, 64'h0,  WRITE_NA, 64'h1000, 12'h080, 1'b0, 0);
        send_line(32, 64'h80, WRITE_NA, 64'h1080, 12'h080, 1'b0, 0);
        rstn = 1'b0;
        #1;
        check("midreset_cmd_valid", 64'(write_command_out.valid), 64'd0);
        check("midreset_data_valid", 64'(write_data_out.valid), 64'd0);
        check("midreset_counter", 64'(write_job_counter_done), 64'd0);
        check("midreset_state", 64'(dut.state_q), 64'(WRITE_STREAM_RESET));
        tick();
        tick();
        rstn = 1'b1;
        repeat (15) tick();
        check("midreset_no_stale", 64'(sb.size()), 64'd0);
        check("midreset_idle", 64'(dut.state_q), 64'(WRITE_STREAM_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
